// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader for the ATMega32A emulator's program memory.
// Framed bytes arrive from the UART receiver over a valid/ready handshake.
// The loader checks each frame and writes the payload through to program
// memory one byte per cycle. While a frame is in progress, the
// instruction-register stage is held in clear.
//
// Frame: SYNC, ADDR_HI, ADDR_LO, LEN, LEN payload bytes (LEN = 0 means 256),
// CSUM. The 8-bit sum of every byte after SYNC, including CSUM, must be 0.
//
// Ports:
//   clk        - single clock, rising edge
//   clr        - synchronous active-high reset
//   load_en    - loader enable; dropping it aborts a frame without error
//   rx_data    - incoming byte
//   rx_valid   - rx_data is valid
//   rx_ready   - loader can take a byte (load_en & ~clr)
//   data       - program memory write data
//   write_addr - program memory byte address
//   WE         - program memory write strobe, one cycle per byte
//   clr_reg_n  - active-low clear to the instruction registers (~busy)
//   busy       - frame in progress
//   done       - one-cycle pulse when a frame ends with a good checksum
//   err        - sticky error flag, cleared by the next SYNC or by clr
//   err_code   - 01 checksum, 10 timeout, 11 address out of range
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter logic [7:0]          SYNC_BYTE = 8'h55,
    parameter int unsigned         TO_WIDTH  = 16,
    parameter logic [TO_WIDTH-1:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  data,
    output logic [14:0] write_addr,
    output logic        WE,
    output logic        clr_reg_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA,
        CSUM
    } state_t;

    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RANGE   = 2'b11;

    // The abort fires on the edge where the counter would step onto TIMEOUT,
    // so the state leaves DATA exactly TIMEOUT cycles after the last byte.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TIMEOUT - 1'b1;

    state_t              state, state_n;
    logic [14:0]         addr, addr_n;
    logic [8:0]          count, count_n;
    logic [7:0]          sum, sum_n;
    logic [TO_WIDTH-1:0] to_cnt, to_cnt_n;
    logic [7:0]          data_n;
    logic [14:0]         write_addr_n;
    logic                we_n;
    logic                done_n;
    logic                err_n;
    logic [1:0]          err_code_n;
    logic                accept;
    logic [7:0]          sum_add;

    assign rx_ready  = load_en & ~clr;
    assign accept    = rx_valid & rx_ready;
    assign sum_add   = sum + rx_data;
    assign busy      = (state != IDLE);
    assign clr_reg_n = ~busy;

    // State and output registers. Everything, including the memory write
    // port, is registered so a byte accepted at one edge is presented to
    // the memory for the following cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            addr       <= '0;
            count      <= '0;
            sum        <= '0;
            to_cnt     <= '0;
            data       <= '0;
            write_addr <= '0;
            WE         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            count      <= count_n;
            sum        <= sum_n;
            to_cnt     <= to_cnt_n;
            data       <= data_n;
            write_addr <= write_addr_n;
            WE         <= we_n;
            done       <= done_n;
            err        <= err_n;
            err_code   <= err_code_n;
        end
    end

    // Next-state logic. Priority is load_en abort, then an accepted byte,
    // then the idle timeout, so a byte arriving on the timeout cycle wins.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        count_n      = count;
        sum_n        = sum;
        to_cnt_n     = to_cnt;
        data_n       = data;
        write_addr_n = write_addr;
        we_n         = 1'b0;
        done_n       = 1'b0;
        err_n        = err;
        err_code_n   = err_code;

        if (state != IDLE && !load_en) begin
            state_n  = IDLE;
            to_cnt_n = '0;
        end else if (accept) begin
            to_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        err_n      = 1'b0;
                        err_code_n = 2'b00;
                        sum_n      = 8'h00;
                        state_n    = ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    // Only 32 KiB of program memory; bit 7 would address past it.
                    if (rx_data[7]) begin
                        state_n    = IDLE;
                        err_n      = 1'b1;
                        err_code_n = ERR_RANGE;
                    end else begin
                        addr_n  = {rx_data[6:0], 8'h00};
                        sum_n   = sum_add;
                        state_n = ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    addr_n  = {addr[14:8], rx_data};
                    sum_n   = sum_add;
                    state_n = LEN;
                end
                LEN: begin
                    count_n = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_n   = sum_add;
                    state_n = DATA;
                end
                DATA: begin
                    data_n       = rx_data;
                    write_addr_n = addr;
                    we_n         = 1'b1;
                    addr_n       = addr + 15'd1;
                    sum_n        = sum_add;
                    count_n      = count - 9'd1;
                    if (count == 9'd1) begin
                        state_n = CSUM;
                    end
                end
                CSUM: begin
                    sum_n   = sum_add;
                    state_n = IDLE;
                    if (sum_add == 8'h00) begin
                        done_n = 1'b1;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_CSUM;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state == IDLE) begin
            to_cnt_n = '0;
        end else if (TIMEOUT != '0 && to_cnt == TO_LAST) begin
            state_n    = IDLE;
            to_cnt_n   = '0;
            err_n      = 1'b1;
            err_code_n = ERR_TIMEOUT;
        end else begin
            to_cnt_n = to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed testbench for prog_loader with TIMEOUT = 100. Each scenario task
// drives a frame and compares outputs against hand-computed values. A
// negedge monitor logs every write strobe and done pulse so that write
// counts and contents can be checked after the fact.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk;
    logic        clr;
    logic        load_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  data;
    logic [14:0] write_addr;
    logic        WE;
    logic        clr_reg_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int total;
    int bad;

    logic [14:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          done_cnt;

    prog_loader #(
        .SYNC_BYTE (8'h55),
        .TO_WIDTH  (16),
        .TIMEOUT   (16'd100)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .load_en    (load_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .data       (data),
        .write_addr (write_addr),
        .WE         (WE),
        .clr_reg_n  (clr_reg_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record memory writes and done pulses mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (WE === 1'b1) begin
            log_addr.push_back(write_addr);
            log_data.push_back(data);
        end
        if (done === 1'b1) begin
            done_cnt++;
        end
    end

    // Present one byte for one edge; rx_valid stays high so calls chain back-to-back.
    task automatic apply_stimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int cycles);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log;
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset;
        clr      = 1'b1;
        load_en  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rx_ready: got %b expected 0", rx_ready);
        end
        total++;
        if ({data, write_addr, WE, busy, done, err, err_code, clr_reg_n} !==
            {8'h00, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got data=%h addr=%h WE=%b busy=%b done=%b err=%b code=%b clr_reg_n=%b expected all zero with clr_reg_n=1",
                     data, write_addr, WE, busy, done, err, err_code, clr_reg_n);
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (rx_ready !== 1'b1 || busy !== 1'b0 || clr_reg_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL after_reset: got rx_ready=%b busy=%b clr_reg_n=%b expected 1 0 1",
                     rx_ready, busy, clr_reg_n);
        end
    endtask

    task automatic test_basic;
        clear_log();
        apply_stimulus(8'h55);
        total++;
        if (busy !== 1'b1 || clr_reg_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy_rise: got busy=%b clr_reg_n=%b expected 1 0", busy, clr_reg_n);
        end
        apply_stimulus(8'h00);
        apply_stimulus(8'h10);
        apply_stimulus(8'h02);
        total++;
        if (WE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_no_early_we: got WE=%b expected 0", WE);
        end
        apply_stimulus(8'hAA);
        total++;
        if ({WE, write_addr, data} !== {1'b1, 15'h0010, 8'hAA}) begin
            bad++;
            $display("[TB] FAIL basic_write0: got WE=%b addr=%h data=%h expected 1 0010 aa", WE, write_addr, data);
        end
        apply_stimulus(8'hBB);
        total++;
        if ({WE, write_addr, data} !== {1'b1, 15'h0011, 8'hBB}) begin
            bad++;
            $display("[TB] FAIL basic_write1: got WE=%b addr=%h data=%h expected 1 0011 bb", WE, write_addr, data);
        end
        apply_stimulus(8'h89);
        total++;
        if ({done, err, busy, WE, clr_reg_n} !== 5'b10001) begin
            bad++;
            $display("[TB] FAIL basic_end: got done=%b err=%b busy=%b WE=%b clr_reg_n=%b expected 1 0 0 0 1",
                     done, err, busy, WE, clr_reg_n);
        end
        go_idle(2);
        total++;
        if (done !== 1'b0 || done_cnt != 1) begin
            bad++;
            $display("[TB] FAIL basic_done_pulse: got done=%b pulses=%0d expected 0 1", done, done_cnt);
        end
        total++;
        if (log_addr.size() != 2) begin
            bad++;
            $display("[TB] FAIL basic_write_count: got %0d expected 2", log_addr.size());
        end
    endtask

    task automatic test_wrap;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h7F);
        apply_stimulus(8'hFF);
        apply_stimulus(8'h02);
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        apply_stimulus(8'h4D);
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_done: got done=%b err=%b expected 1 0", done, err);
        end
        go_idle(2);
        total++;
        if (log_addr.size() != 2) begin
            bad++;
            $display("[TB] FAIL wrap_count: got %0d expected 2", log_addr.size());
        end else begin
            total++;
            if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !==
                {15'h7FFF, 8'h11, 15'h0000, 8'h22}) begin
                bad++;
                $display("[TB] FAIL wrap_writes: got %h=%h %h=%h expected 7fff=11 0000=22",
                         log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
    endtask

    task automatic test_bad_csum;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h00);
        apply_stimulus(8'h10);
        apply_stimulus(8'h02);
        apply_stimulus(8'hAA);
        apply_stimulus(8'hBB);
        apply_stimulus(8'h88);
        total++;
        if ({done, err, err_code, busy} !== {1'b0, 1'b1, 2'b01, 1'b0}) begin
            bad++;
            $display("[TB] FAIL csum_err: got done=%b err=%b code=%b busy=%b expected 0 1 01 0",
                     done, err, err_code, busy);
        end
        go_idle(5);
        total++;
        if (err !== 1'b1 || err_code !== 2'b01 || done_cnt != 0 || log_addr.size() != 2) begin
            bad++;
            $display("[TB] FAIL csum_sticky: got err=%b code=%b done_pulses=%0d writes=%0d expected 1 01 0 2",
                     err, err_code, done_cnt, log_addr.size());
        end
        apply_stimulus(8'h55);
        total++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            bad++;
            $display("[TB] FAIL csum_clear_on_sync: got err=%b code=%b expected 0 00", err, err_code);
        end
        apply_stimulus(8'h00);
        apply_stimulus(8'h10);
        apply_stimulus(8'h02);
        apply_stimulus(8'hAA);
        apply_stimulus(8'hBB);
        apply_stimulus(8'h89);
        go_idle(2);
        total++;
        if (done_cnt != 1 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL csum_recovery: got done_pulses=%0d err=%b expected 1 0", done_cnt, err);
        end
    endtask

    task automatic test_range;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h80);
        total++;
        if ({err, err_code, busy} !== {1'b1, 2'b11, 1'b0}) begin
            bad++;
            $display("[TB] FAIL range_err: got err=%b code=%b busy=%b expected 1 11 0", err, err_code, busy);
        end
        apply_stimulus(8'h00);
        apply_stimulus(8'h02);
        apply_stimulus(8'hAA);
        apply_stimulus(8'hBB);
        go_idle(2);
        total++;
        if (busy !== 1'b0 || err_code !== 2'b11 || log_addr.size() != 0) begin
            bad++;
            $display("[TB] FAIL range_ignore_trailing: got busy=%b code=%b writes=%0d expected 0 11 0",
                     busy, err_code, log_addr.size());
        end
    endtask

    task automatic test_timeout;
        int early_drop;
        clear_log();
        early_drop = 0;
        apply_stimulus(8'h55);
        apply_stimulus(8'h00);
        rx_valid = 1'b0;
        for (int i = 1; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) early_drop++;
        end
        total++;
        if (early_drop != 0) begin
            bad++;
            $display("[TB] FAIL timeout_early: got %0d cycles with busy=0 expected 0", early_drop);
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, err, err_code} !== {1'b0, 1'b1, 2'b10} || log_addr.size() != 0) begin
            bad++;
            $display("[TB] FAIL timeout_abort: got busy=%b err=%b code=%b writes=%0d expected 0 1 10 0",
                     busy, err, err_code, log_addr.size());
        end
        // Stall of 99 idle cycles, byte lands on the timeout edge and wins.
        apply_stimulus(8'h55);
        apply_stimulus(8'h00);
        go_idle(99);
        apply_stimulus(8'h10);
        total++;
        if ({busy, err} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL timeout_byte_wins: got busy=%b err=%b expected 1 0", busy, err);
        end
        apply_stimulus(8'h01);
        apply_stimulus(8'hAA);
        apply_stimulus(8'h45);
        go_idle(2);
        total++;
        if (done_cnt != 1 || err !== 1'b0 || log_addr.size() != 1) begin
            bad++;
            $display("[TB] FAIL timeout_frame_ok: got done_pulses=%0d err=%b writes=%0d expected 1 0 1",
                     done_cnt, err, log_addr.size());
        end
    endtask

    task automatic test_load_en_abort;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h00);
        apply_stimulus(8'h20);
        apply_stimulus(8'h00);
        apply_stimulus(8'h01);
        apply_stimulus(8'h02);
        apply_stimulus(8'h03);
        rx_valid = 1'b0;
        load_en  = 1'b0;
        #1;
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_en_ready: got %b expected 0", rx_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, err, clr_reg_n} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL load_en_abort: got busy=%b err=%b clr_reg_n=%b expected 0 0 1", busy, err, clr_reg_n);
        end
        go_idle(4);
        total++;
        if (log_addr.size() != 3 || log_addr[2] !== 15'h0022 || log_data[2] !== 8'h03) begin
            bad++;
            $display("[TB] FAIL load_en_writes: got count=%0d expected 3 ending 0022=03", log_addr.size());
        end
        load_en = 1'b1;
    endtask

    task automatic test_clr_mid_data;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h00);
        apply_stimulus(8'h30);
        apply_stimulus(8'h04);
        apply_stimulus(8'hA1);
        apply_stimulus(8'hA2);
        rx_data = 8'hA3;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({data, write_addr, WE, busy, done, err, err_code, clr_reg_n, rx_ready} !==
            {8'h00, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL clr_mid_data: got data=%h addr=%h WE=%b busy=%b done=%b err=%b code=%b clr_reg_n=%b rx_ready=%b expected reset values",
                     data, write_addr, WE, busy, done, err, err_code, clr_reg_n, rx_ready);
        end
        clr = 1'b0;
        apply_stimulus(8'hA4);
        go_idle(3);
        total++;
        if (log_addr.size() != 2 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_no_more_we: got writes=%0d busy=%b expected 2 0", log_addr.size(), busy);
        end
    endtask

    task automatic test_back_to_back;
        clear_log();
        apply_stimulus(8'h55);
        apply_stimulus(8'h01);
        apply_stimulus(8'h00);
        apply_stimulus(8'h01);
        apply_stimulus(8'h5A);
        apply_stimulus(8'hA4);
        apply_stimulus(8'h55);
        apply_stimulus(8'h01);
        apply_stimulus(8'h01);
        apply_stimulus(8'h01);
        apply_stimulus(8'h5B);
        apply_stimulus(8'hA2);
        go_idle(2);
        total++;
        if (done_cnt != 2 || err !== 1'b0 || log_addr.size() != 2) begin
            bad++;
            $display("[TB] FAIL b2b_frames: got done_pulses=%0d err=%b writes=%0d expected 2 0 2",
                     done_cnt, err, log_addr.size());
        end else begin
            total++;
            if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !==
                {15'h0100, 8'h5A, 15'h0101, 8'h5B}) begin
                bad++;
                $display("[TB] FAIL b2b_writes: got %h=%h %h=%h expected 0100=5a 0101=5b",
                         log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        clr      = 1'b1;
        load_en  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_csum();
        test_range();
        test_timeout();
        test_load_en_abort();
        test_clr_mid_data();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
